// File: rtl/aes_kslot_pkg.sv
// ============================================================================
// Module  : aes_kslot_pkg
// Brief   : Register word map, status bit positions and sequencer states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_kslot_pkg;
    localparam int unsigned CTRL       = 0;
    localparam int unsigned STATUS     = 1;
    localparam int unsigned KEY_SEL    = 2;
    localparam int unsigned LOCK       = 3;
    localparam int unsigned PT_BASE    = 4;
    localparam int unsigned ST_BASE    = 8;
    localparam int unsigned CT_BASE    = 12;
    localparam int unsigned KEY_BASE   = 16;
    localparam int unsigned KEY_STRIDE = 8;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_TIMEOUT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } ctrl_state_e;
endpackage

`default_nettype wire

// File: rtl/aes_kslot_bank.sv
// ============================================================================
// Module  : aes_kslot_bank
// Brief   : Key-slot storage with write-1-to-set locks and a selected-slot read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_kslot_bank
    import aes_kslot_pkg::*;
#(
    parameter int NUM_KEYS  = 4,
    parameter int KEY_WIDTH = 192
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [2:0]           slot_i,
    input  logic [2:0]           word_i,
    input  logic [31:0]          wdata_i,
    input  logic                 lock_we_i,
    input  logic [NUM_KEYS-1:0]  lock_set_i,
    input  logic [2:0]           sel_i,
    output logic [KEY_WIDTH-1:0] key_o,
    output logic [NUM_KEYS-1:0]  lock_o,
    output logic                 lock_viol_o
);
    localparam int KEY_WORDS = KEY_WIDTH / 32;

    logic [KEY_WORDS-1:0][31:0] slot_q [NUM_KEYS];
    logic [KEY_WORDS-1:0][31:0] slot_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]        lock_q;
    logic [NUM_KEYS-1:0]        lock_d;
    logic                       w_sel_locked;

    always_comb begin
        slot_d       = slot_q;
        lock_d       = lock_q;
        key_o        = '0;
        w_sel_locked = 1'b0;
        if (lock_we_i) begin
            lock_d = lock_q | lock_set_i;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (slot_i == 3'(k)) begin
                w_sel_locked = lock_q[k];
            end
            if (sel_i == 3'(k)) begin
                key_o = slot_q[k];
            end
            // A locked slot silently drops the word; the caller flags the error.
            for (int j = 0; j < KEY_WORDS; j++) begin
                if (wr_en_i && !lock_q[k] && (slot_i == 3'(k)) && (word_i == 3'(j))) begin
                    slot_d[k][j] = wdata_i;
                end
            end
        end
    end

    assign lock_o      = lock_q;
    assign lock_viol_o = wr_en_i & w_sel_locked;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                slot_q[k] <= '0;
            end
            lock_q <= '0;
        end else begin
            slot_q <= slot_d;
            lock_q <= lock_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/aes_keyslot_ctrl.sv
// ============================================================================
// Module  : aes_keyslot_ctrl
// Brief   : AES register front-end: key slots, operands and launch sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_keyslot_ctrl
    import aes_kslot_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int KEY_WIDTH      = 192,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bus_valid_i,
    input  logic                 bus_write_i,
    input  logic [31:0]          bus_addr_i,
    input  logic [31:0]          bus_wdata_i,
    output logic                 bus_ready_o,
    output logic [31:0]          bus_rdata_o,
    output logic                 bus_error_o,
    output logic                 core_start_o,
    output logic [KEY_WIDTH-1:0] core_key_o,
    output logic [127:0]         core_pt_o,
    output logic [127:0]         core_state_o,
    input  logic [127:0]         core_ct_i,
    input  logic                 core_valid_i,
    output logic                 irq_o
);
    localparam int KEY_WORDS = KEY_WIDTH / 32;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);

    ctrl_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           key_sel_q, key_sel_d;
    logic                 irq_en_q, irq_en_d;
    logic [3:0][31:0]     pt_q, pt_d, st_q, st_d, ct_q, ct_d;
    logic                 done_q, done_d, err_q, err_d, timeout_q, timeout_d;
    logic                 core_start_q, core_start_d;
    logic [KEY_WIDTH-1:0] core_key_q, core_key_d;
    logic [3:0][31:0]     core_pt_q, core_pt_d, core_state_q, core_state_d;

    logic [7:0]           w_idx, w_key_rel;
    logic                 w_busy, w_is_key, w_key_wr, w_lock_viol;
    logic [KEY_WIDTH-1:0] w_bank_key;
    logic [NUM_KEYS-1:0]  w_lock;
    logic                 w_err, w_start, w_clear, w_ksel_wr, w_lock_we, w_pt_wr, w_st_wr;
    logic [31:0]          w_rdata;
    logic                 w_unused_addr;

    assign w_idx         = bus_addr_i[9:2];
    assign w_unused_addr = ^{bus_addr_i[31:10], bus_addr_i[1:0]};
    assign w_key_rel     = w_idx - 8'(KEY_BASE);
    assign w_busy        = (state_q != IDLE);
    assign w_is_key      = (w_idx >= 8'(KEY_BASE)) &&
                           (w_key_rel < 8'(KEY_STRIDE * NUM_KEYS)) &&
                           ({5'd0, w_key_rel[2:0]} < 8'(KEY_WORDS));
    assign w_key_wr      = bus_valid_i & bus_write_i & w_is_key & ~w_busy;

    aes_kslot_bank #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_WIDTH (KEY_WIDTH)
    ) u_bank (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (w_key_wr),
        .slot_i      (w_key_rel[5:3]),
        .word_i      (w_key_rel[2:0]),
        .wdata_i     (bus_wdata_i),
        .lock_we_i   (w_lock_we),
        .lock_set_i  (bus_wdata_i[NUM_KEYS-1:0]),
        .sel_i       (key_sel_q),
        .key_o       (w_bank_key),
        .lock_o      (w_lock),
        .lock_viol_o (w_lock_viol)
    );

    // Register decode: every rejected access leaves all state except err untouched.
    always_comb begin
        w_err     = 1'b0;
        w_rdata   = '0;
        w_start   = 1'b0;
        w_clear   = 1'b0;
        w_ksel_wr = 1'b0;
        w_lock_we = 1'b0;
        w_pt_wr   = 1'b0;
        w_st_wr   = 1'b0;
        if (bus_valid_i) begin
            if (w_idx == 8'(CTRL)) begin
                if (bus_write_i) begin
                    if (bus_wdata_i[0] && w_busy) begin
                        w_err = 1'b1;
                    end else begin
                        w_start = bus_wdata_i[0];
                        w_clear = bus_wdata_i[1];
                    end
                end
            end else if (w_idx == 8'(STATUS)) begin
                if (bus_write_i) begin
                    w_err = 1'b1;
                end else begin
                    w_rdata[STAT_BUSY]    = w_busy;
                    w_rdata[STAT_DONE]    = done_q;
                    w_rdata[STAT_ERR]     = err_q;
                    w_rdata[STAT_TIMEOUT] = timeout_q;
                end
            end else if (w_idx == 8'(KEY_SEL)) begin
                if (bus_write_i) begin
                    if (w_busy || ({1'b0, bus_wdata_i[2:0]} >= 4'(NUM_KEYS))) begin
                        w_err = 1'b1;
                    end else begin
                        w_ksel_wr = 1'b1;
                    end
                end else begin
                    w_rdata[2:0] = key_sel_q;
                    w_rdata[8]   = irq_en_q;
                end
            end else if (w_idx == 8'(LOCK)) begin
                if (bus_write_i) begin
                    w_lock_we = 1'b1;
                end else begin
                    w_rdata[NUM_KEYS-1:0] = w_lock;
                end
            end else if (w_idx[7:2] == 6'(PT_BASE / 4)) begin
                if (bus_write_i) begin
                    w_err   = w_busy;
                    w_pt_wr = ~w_busy;
                end else begin
                    w_rdata = pt_q[w_idx[1:0]];
                end
            end else if (w_idx[7:2] == 6'(ST_BASE / 4)) begin
                if (bus_write_i) begin
                    w_err   = w_busy;
                    w_st_wr = ~w_busy;
                end else begin
                    w_rdata = st_q[w_idx[1:0]];
                end
            end else if (w_idx[7:2] == 6'(CT_BASE / 4)) begin
                if (bus_write_i) begin
                    w_err = 1'b1;
                end else begin
                    w_rdata = ct_q[w_idx[1:0]];
                end
            end else if (w_is_key) begin
                if (bus_write_i) begin
                    w_err = w_busy | w_lock_viol;
                end
            end else begin
                w_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_sel_d    = key_sel_q;
        irq_en_d     = irq_en_q;
        pt_d         = pt_q;
        st_d         = st_q;
        ct_d         = ct_q;
        done_d       = done_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        core_start_d = 1'b0;
        core_key_d   = core_key_q;
        core_pt_d    = core_pt_q;
        core_state_d = core_state_q;

        if (w_clear) begin
            done_d    = 1'b0;
            err_d     = 1'b0;
            timeout_d = 1'b0;
        end
        if (w_err) begin
            err_d = 1'b1;
        end
        if (w_ksel_wr) begin
            key_sel_d = bus_wdata_i[2:0];
            irq_en_d  = bus_wdata_i[8];
        end
        if (w_pt_wr) begin
            pt_d[w_idx[1:0]] = bus_wdata_i;
        end
        if (w_st_wr) begin
            st_d[w_idx[1:0]] = bus_wdata_i;
        end

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    core_key_d   = w_bank_key;
                    core_pt_d    = pt_q;
                    core_state_d = st_q;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    core_start_d = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_valid_i) begin
                    ct_d    = core_ct_i;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_sel_q    <= '0;
            irq_en_q     <= 1'b0;
            pt_q         <= '0;
            st_q         <= '0;
            ct_q         <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_key_q   <= '0;
            core_pt_q    <= '0;
            core_state_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_sel_q    <= key_sel_d;
            irq_en_q     <= irq_en_d;
            pt_q         <= pt_d;
            st_q         <= st_d;
            ct_q         <= ct_d;
            done_q       <= done_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            core_start_q <= core_start_d;
            core_key_q   <= core_key_d;
            core_pt_q    <= core_pt_d;
            core_state_q <= core_state_d;
        end
    end

    assign bus_ready_o  = bus_valid_i;
    assign bus_rdata_o  = w_rdata;
    assign bus_error_o  = w_err;
    assign core_start_o = core_start_q;
    assign core_key_o   = core_key_q;
    assign core_pt_o    = core_pt_q;
    assign core_state_o = core_state_q;
    assign irq_o        = done_q & irq_en_q;
endmodule

`default_nettype wire

// File: tb/tb_aes_keyslot_ctrl.sv
// ============================================================================
// Module  : tb_aes_keyslot_ctrl
// Brief   : Scoreboard bench for aes_keyslot_ctrl against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_keyslot_ctrl;
    localparam int NK     = 4;
    localparam int KWB    = 192;
    localparam int KWORDS = KWB / 32;
    localparam int TO     = 16;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           bus_valid_i = 1'b0, bus_write_i = 1'b0;
    logic [31:0]    bus_addr_i = '0, bus_wdata_i = '0;
    logic           bus_ready_o, bus_error_o, core_start_o, irq_o;
    logic [31:0]    bus_rdata_o;
    logic [KWB-1:0] core_key_o;
    logic [127:0]   core_pt_o, core_state_o;
    logic [127:0]   core_ct_i = '0;
    logic           core_valid_i = 1'b0;

    aes_keyslot_ctrl #(.NUM_KEYS(NK), .KEY_WIDTH(KWB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .bus_valid_i(bus_valid_i), .bus_write_i(bus_write_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_ready_o(bus_ready_o),
        .bus_rdata_o(bus_rdata_o), .bus_error_o(bus_error_o), .core_start_o(core_start_o),
        .core_key_o(core_key_o), .core_pt_o(core_pt_o), .core_state_o(core_state_o),
        .core_ct_i(core_ct_i), .core_valid_i(core_valid_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { string nm; bit rd; logic [31:0] rdata; bit err; bit irq; } bus_exp_t;
    typedef struct { int c; logic [KWB-1:0] key; logic [127:0] pt; logic [127:0] st; } start_exp_t;
    bus_exp_t   sb_q[$];
    start_exp_t st_q[$];

    // ---------------- behavioural reference model ----------------
    logic [31:0]  m_key [NK][8];
    bit [NK-1:0]  m_lock;
    int           m_ksel;
    bit           m_irq_en, m_done, m_err, m_to, m_run;
    logic [31:0]  m_pt [4], m_st [4], m_ct [4];
    int           m_t;
    logic [127:0] m_snap_pt;

    function automatic void m_reset();
        for (int k = 0; k < NK; k++) for (int j = 0; j < 8; j++) m_key[k][j] = '0;
        for (int i = 0; i < 4; i++) begin m_pt[i] = '0; m_st[i] = '0; m_ct[i] = '0; end
        m_lock = '0; m_ksel = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_to = 0; m_run = 0;
        m_t = 0; m_snap_pt = '0;
    endfunction

    // A run started in cycle t is busy in cycles t+1 .. t+1+TO unless answered.
    function automatic void m_settle(int c);
        if (m_run && c > m_t + 1 + TO) begin m_run = 0; m_to = 1; end
    endfunction

    function automatic bit m_busy(int c);
        return m_run && c >= m_t + 1;
    endfunction

    function automatic void m_launch(int c);
        start_exp_t s;
        s.c = c + 1;
        for (int j = 0; j < KWORDS; j++) s.key[32*j +: 32] = m_key[m_ksel][j];
        s.pt = {m_pt[3], m_pt[2], m_pt[1], m_pt[0]};
        s.st = {m_st[3], m_st[2], m_st[1], m_st[0]};
        st_q.push_back(s);
        m_snap_pt = s.pt;
        m_done = 0; m_to = 0; m_run = 1; m_t = c;
    endfunction

    function automatic void m_access(input bit wr, input int idx, input logic [31:0] wd,
                                     input int c, output logic [31:0] rd, output bit er);
        bit busy;
        busy = m_busy(c);
        rd = '0; er = 0;
        if (idx == 0) begin
            if (wr) begin
                if (wd[0] && busy) er = 1;
                else begin
                    if (wd[1]) begin m_done = 0; m_err = 0; m_to = 0; end
                    if (wd[0]) m_launch(c);
                end
            end
        end else if (idx == 1) begin
            if (wr) er = 1;
            else rd = {28'd0, m_to, m_err, m_done, busy};
        end else if (idx == 2) begin
            if (wr) begin
                if (busy || int'(wd[2:0]) >= NK) er = 1;
                else begin m_ksel = int'(wd[2:0]); m_irq_en = wd[8]; end
            end else rd = (32'(m_irq_en) << 8) | 32'(m_ksel);
        end else if (idx == 3) begin
            if (wr) m_lock = m_lock | wd[NK-1:0];
            else rd = 32'(m_lock);
        end else if (idx >= 4 && idx < 8) begin
            if (wr) begin if (busy) er = 1; else m_pt[idx-4] = wd; end
            else rd = m_pt[idx-4];
        end else if (idx >= 8 && idx < 12) begin
            if (wr) begin if (busy) er = 1; else m_st[idx-8] = wd; end
            else rd = m_st[idx-8];
        end else if (idx >= 12 && idx < 16) begin
            if (wr) er = 1; else rd = m_ct[idx-12];
        end else if (idx >= 16 && idx < 16 + 8*NK && ((idx - 16) % 8) < KWORDS) begin
            if (wr) begin
                if (busy || m_lock[(idx-16)/8]) er = 1;
                else m_key[(idx-16)/8][(idx-16)%8] = wd;
            end
        end else begin
            er = 1;
        end
        if (er) m_err = 1;
    endfunction

    // ---------------- stimulus tasks (start just after a rising edge) ----------------
    task automatic acc(input bit wr, input int idx, input logic [31:0] wd, input string nm);
        bus_exp_t e;
        logic [31:0] a;
        int c;
        c = cyc;
        m_settle(c);
        e.nm = nm; e.rd = !wr; e.irq = m_done && m_irq_en;
        m_access(wr, idx, wd, c, e.rdata, e.err);
        sb_q.push_back(e);
        a = ($urandom() & 32'hFFFF_FC03) | (32'(idx) << 2);
        bus_valid_i = 1'b1; bus_write_i = wr; bus_addr_i = a; bus_wdata_i = wd;
        @(posedge clk); #1;
        bus_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            core_ct_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
    endtask

    task automatic core_resp(input logic [127:0] ct);
        int c;
        c = cyc;
        m_settle(c);
        if (m_run && c >= m_t + 2) begin
            m_ct[0] = ct[31:0]; m_ct[1] = ct[63:32]; m_ct[2] = ct[95:64]; m_ct[3] = ct[127:96];
            m_done = 1; m_run = 0;
        end
        core_valid_i = 1'b1; core_ct_i = ct;
        @(posedge clk); #1;
        core_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_reset();
    endtask

    task automatic chk_zero_outputs(input string tag);
        check({tag, "_core_key"}, core_key_o, '0);
        check({tag, "_core_pt"}, core_pt_o, '0);
        check({tag, "_core_state"}, core_state_o, '0);
        check({tag, "_irq"}, irq_o, '0);
        check({tag, "_core_start"}, core_start_o, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus_ready_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL bus_unexpected: ready at cycle %0d with no expectation", cyc);
            end else begin
                bus_exp_t e;
                e = sb_q.pop_front();
                check({e.nm, "_err"}, bus_error_o, e.err);
                check({e.nm, "_irq"}, irq_o, e.irq);
                if (e.rd) check({e.nm, "_rdata"}, bus_rdata_o, e.rdata);
            end
        end
        if (core_start_o === 1'b1) begin
            if (st_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL start_unexpected: core_start_o at cycle %0d", cyc);
            end else begin
                start_exp_t s;
                s = st_q.pop_front();
                check("start_cycle", cyc, s.c);
                check("start_key", core_key_o, s.key);
                check("start_pt", core_pt_o, s.pt);
                check("start_state", core_state_o, s.st);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int          r, idx;
    bit          wr;
    logic [31:0] wd;

    initial begin
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;
        chk_zero_outputs("reset");
        acc(0, 1, 0, "rst_status"); acc(0, 2, 0, "rst_keysel"); acc(0, 3, 0, "rst_lock");
        acc(0, 4, 0, "rst_pt");     acc(0, 12, 0, "rst_ct");

        // Basic encryption from slot 2.
        for (int j = 0; j < KWORDS; j++) acc(1, 16 + 8*2 + j, 32'(j), "wr_key2");
        for (int j = 0; j < 4; j++) acc(1, 4 + j, 32'h1122_3344, "wr_pt");
        for (int j = 0; j < 4; j++) acc(1, 8 + j, 32'hA5A5_0000 + 32'(j), "wr_st");
        acc(1, 2, 32'h0000_0102, "wr_keysel");
        acc(1, 0, 32'h1, "start1");
        idle(4);
        core_resp(128'hCAFE_BABE_0123_4567_89AB_CDEF_DEAD_BEEF);
        for (int j = 0; j < 4; j++) acc(0, 12 + j, 0, "ct1");
        acc(0, 1, 0, "status_done");

        // Lock slot 2, then try to overwrite it.
        acc(1, 3, 32'h4, "wr_lock");
        acc(1, 16 + 16, 32'hFFFF_FFFF, "wr_locked_key");
        acc(0, 1, 0, "status_err");
        acc(1, 0, 32'h2, "clear");
        acc(0, 1, 0, "status_cleared");
        acc(0, 3, 0, "lock_kept");
        acc(1, 0, 32'h3, "clear_start");
        idle(2);
        core_resp(128'h1);

        // Busy rejections, then watchdog expiry and a late response.
        acc(1, 0, 32'h1, "start3");
        acc(1, 4, 32'hDEAD_0000, "busy_wr_pt");
        acc(1, 0, 32'h1, "busy_start");
        acc(1, 2, 32'h1, "busy_keysel");
        check("busy_core_pt", core_pt_o, m_snap_pt);
        acc(0, 4, 0, "pt_kept");
        acc(1, 0, 32'h2, "busy_clear");
        for (int i = 0; i < TO + 2; i++) acc(0, 1, 0, "status_to");
        core_resp(128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0);
        acc(0, 12, 0, "ct_after_late");
        acc(0, 1, 0, "status_after_late");

        // Out-of-range key select and unmapped word.
        acc(1, 2, 32'(NK), "keysel_oob");
        acc(0, 2, 0, "keysel_kept");
        acc(0, 200, 0, "unmapped_rd");
        acc(1, 16 + 8*0 + KWORDS, 32'h5, "unmapped_keyword");

        // Reset in the middle of a run.
        acc(1, 0, 32'h3, "start_rst");
        idle(4);
        do_reset();
        chk_zero_outputs("midrun_reset");
        acc(0, 3, 0, "lock_after_rst");
        acc(0, 16 + 16, 0, "key_after_rst");
        core_resp(128'h1234);
        acc(0, 1, 0, "status_after_rst");
        acc(0, 12, 0, "ct_after_rst");

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else if (r < 14) core_resp({$urandom(), $urandom(), $urandom(), $urandom()});
            else if (r < 30) idle(1);
            else begin
                idx = $urandom_range(0, 16 + 8*NK + 3);
                if ($urandom_range(0, 19) == 0) idx = $urandom_range(0, 255);
                wr = 1'($urandom_range(0, 1));
                wd = $urandom();
                if ($urandom_range(0, 5) == 0) begin idx = 0; wr = 1; end
                if (idx == 0) wd = 32'($urandom_range(0, 3));
                if (idx == 2) wd = (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 5));
                if (idx == 3 && $urandom_range(0, 7) != 0) wd = '0;
                acc(wr, idx, wd, "rnd");
            end
        end

        idle(3);
        check("sb_drained", sb_q.size(), 0);
        check("starts_drained", st_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
